// File: rtl/fp4_e2m1_pkg.sv
// Shared E2M1 FP4 types and decode constants for the FP4 dot-product datapath.
// Values are expressed in half-units (LSB = 0.5).
package fp4_e2m1_pkg;

   typedef struct packed {
      logic       sign;
      logic [2:0] mag;
   } fp4_e2m1_t;

   localparam logic [2:0] MAG_0P0 = 3'b000;
   localparam logic [2:0] MAG_0P5 = 3'b001;
   localparam logic [2:0] MAG_1P0 = 3'b010;
   localparam logic [2:0] MAG_1P5 = 3'b011;
   localparam logic [2:0] MAG_2P0 = 3'b100;
   localparam logic [2:0] MAG_3P0 = 3'b101;
   localparam logic [2:0] MAG_4P0 = 3'b110;
   localparam logic [2:0] MAG_6P0 = 3'b111;

   localparam int TERM_W = 5;

   // Indexed by magnitude code; entry 0 is code 000.
   localparam logic [7:0][3:0] HALF_UNIT_LUT = {
      4'd12, 4'd8, 4'd6, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0
   };

   typedef enum logic {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } acc_state_t;

   function automatic logic [3:0] half_units(input logic [2:0] mag);
      return HALF_UNIT_LUT[mag];
   endfunction

endpackage

// File: rtl/fp4_e2m1_to_fixed.sv
// Combinational decode of one E2M1 FP4 value to a signed 5-bit half-unit term.
// Kept standalone so a future carry-save accumulation tree can reuse it.
module fp4_e2m1_to_fixed
   import fp4_e2m1_pkg::*;
(
   input  fp4_e2m1_t                fp_i,
   output logic signed [TERM_W-1:0] term_o
);

   logic signed [TERM_W-1:0] mag_s;

   always_comb begin
      mag_s = signed'({1'b0, half_units(fp_i.mag)});
      // Negative zero must still contribute exactly 0.
      if (fp_i.mag == MAG_0P0) begin
         term_o = '0;
      end else if (fp_i.sign) begin
         term_o = -mag_s;
      end else begin
         term_o = mag_s;
      end
   end

endmodule

// File: rtl/fp4_dot_accumulator.sv
// Streaming FP4 product accumulator: sums a vector of E2M1 products in half-units.
// Define FP4_ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module fp4_dot_accumulator
   import fp4_e2m1_pkg::*;
#(
   parameter int ACC_W = 16,
   parameter int CNT_W = 8
)
(
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [3:0]              in_data_i,
   input  logic                    in_last_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic signed [ACC_W-1:0] out_sum_o,
   output logic [CNT_W-1:0]        out_count_o,
   output logic                    out_ovf_o
);

   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   acc_state_t               state_p0;
   logic                     in_ready_p0;
   logic                     out_valid_p0;
   logic signed [ACC_W-1:0]  acc_p0;
   logic [CNT_W-1:0]         count_p0;
   logic                     ovf_p0;

   fp4_e2m1_t                in_fp;
   logic signed [TERM_W-1:0] term;
   logic signed [ACC_W-1:0]  term_ext;
   logic signed [ACC_W-1:0]  raw_sum;
   logic signed [ACC_W-1:0]  acc_next;
   logic                     add_ovf;
   logic                     accept;

   function automatic logic signed [ACC_W-1:0] sat_f(
      input logic signed [ACC_W-1:0] sum,
      input logic                    ovf,
      input logic                    neg
   );
      if (!ovf) return sum;
      return neg ? ACC_MIN : ACC_MAX;
   endfunction

   assign in_fp = fp4_e2m1_t'(in_data_i);

   fp4_e2m1_to_fixed u_decode (
      .fp_i   (in_fp),
      .term_o (term)
   );

   always_comb begin
      term_ext = ACC_W'(term);
      raw_sum  = acc_p0 + term_ext;
      add_ovf  = (acc_p0[ACC_W-1] == term_ext[ACC_W-1]) &&
                 (raw_sum[ACC_W-1] != acc_p0[ACC_W-1]);
`ifdef FP4_ACC_SATURATE_EN
      // Direction of the clamp follows the operands' common sign.
      acc_next = sat_f(raw_sum, add_ovf, acc_p0[ACC_W-1]);
`else
      acc_next = raw_sum;
`endif
   end

   assign accept = in_valid_i & in_ready_p0;

   // Stage p0: control FSM and accumulator state, all outputs registered
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_p0     <= ACCUM;
         in_ready_p0  <= 1'b1;
         out_valid_p0 <= 1'b0;
         acc_p0       <= '0;
         count_p0     <= '0;
         ovf_p0       <= 1'b0;
      end else begin
         case (state_p0)
            ACCUM: begin
               if (accept) begin
                  acc_p0 <= acc_next;
                  ovf_p0 <= ovf_p0 | add_ovf;
                  if (count_p0 != {CNT_W{1'b1}}) begin
                     count_p0 <= count_p0 + CNT_W'(1);
                  end
                  if (in_last_i) begin
                     state_p0     <= DONE;
                     in_ready_p0  <= 1'b0;
                     out_valid_p0 <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (out_ready_i) begin
                  state_p0     <= ACCUM;
                  in_ready_p0  <= 1'b1;
                  out_valid_p0 <= 1'b0;
                  acc_p0       <= '0;
                  count_p0     <= '0;
                  ovf_p0       <= 1'b0;
               end
            end
            default: begin
               state_p0     <= ACCUM;
               in_ready_p0  <= 1'b1;
               out_valid_p0 <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready_o  = in_ready_p0;
   assign out_valid_o = out_valid_p0;
   assign out_sum_o   = acc_p0;
   assign out_count_o = count_p0;
   assign out_ovf_o   = ovf_p0;

endmodule

// File: tb/tb_fp4_dot_accumulator.sv
// Scoreboard bench for fp4_dot_accumulator: a wide (16/8) and a narrow (6/2) instance share one stimulus stream.
// Narrow-instance overflow expectations follow FP4_ACC_SATURATE_EN.
module tb_fp4_dot_accumulator;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_last = 1'b0;
   logic       out_ready = 1'b1;
   logic [3:0] in_data = 4'h0;

   logic        in_ready_w, out_valid_w, ovf_w;
   logic [15:0] sum_w;
   logic [7:0]  cnt_w;
   logic        in_ready_n, out_valid_n, ovf_n;
   logic [5:0]  sum_n;
   logic [1:0]  cnt_n;

   always #5 clk = ~clk;

   fp4_dot_accumulator #(.ACC_W(16), .CNT_W(8)) u_dut_w (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_w),
      .in_data_i(in_data), .in_last_i(in_last), .out_valid_o(out_valid_w),
      .out_ready_i(out_ready), .out_sum_o(sum_w), .out_count_o(cnt_w), .out_ovf_o(ovf_w)
   );

   fp4_dot_accumulator #(.ACC_W(6), .CNT_W(2)) u_dut_n (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_n),
      .in_data_i(in_data), .in_last_i(in_last), .out_valid_o(out_valid_n),
      .out_ready_i(out_ready), .out_sum_o(sum_n), .out_count_o(cnt_n), .out_ovf_o(ovf_n)
   );

   typedef struct packed {
      logic [15:0] sum_w;
      logic [7:0]  cnt_w;
      logic        ovf_w;
      logic [5:0]  sum_n;
      logic [1:0]  cnt_n;
      logic        ovf_n;
   } exp_t;

`ifdef FP4_ACC_SATURATE_EN
   localparam logic [5:0] N_POS_OVF = 6'h1F;  // +31 clamp
   localparam logic [5:0] N_NEG_OVF = 6'h20;  // -32 clamp
`else
   localparam logic [5:0] N_POS_OVF = 6'h24;  // 36 wraps to -28
   localparam logic [5:0] N_NEG_OVF = 6'h1C;  // -36 wraps to +28
`endif

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic exp_t mk(input logic [15:0] sw, input logic [7:0] cw, input logic ow,
                               input logic [5:0] sn, input logic [1:0] cn, input logic on);
      exp_t e;
      e.sum_w = sw; e.cnt_w = cw; e.ovf_w = ow;
      e.sum_n = sn; e.cnt_n = cn; e.ovf_n = on;
      return e;
   endfunction

   always @(negedge clk) begin
      if (!rst && out_valid_w && out_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_result: sum_w=0x%0h with empty scoreboard", sum_w);
         end else begin
            mon_e = sb.pop_front();
            chk("sum_w",   32'(sum_w), 32'(mon_e.sum_w));
            chk("count_w", 32'(cnt_w), 32'(mon_e.cnt_w));
            chk("ovf_w",   32'(ovf_w), 32'(mon_e.ovf_w));
            chk("valid_n", 32'(out_valid_n), 32'd1);
            chk("sum_n",   32'(sum_n), 32'(mon_e.sum_n));
            chk("count_n", 32'(cnt_n), 32'(mon_e.cnt_n));
            chk("ovf_n",   32'(ovf_n), 32'(mon_e.ovf_n));
         end
      end
   end

   // Called and returns at posedge+1; waits (bounded) for in_ready, then holds one accept edge.
   task automatic send(input logic [3:0] d, input logic l, output int waits);
      in_valid = 1'b1; in_data = d; in_last = l;
      waits = 0;
      while (!in_ready_w && waits < 50) begin
         @(posedge clk); #1;
         waits++;
      end
      if (waits >= 50) begin
         n_checks++;
         $display("FAIL ready_timeout: in_ready stayed 0 for %0d cycles, expected 1", waits);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = 4'($urandom); in_last = 1'($urandom);
      if (l) begin
         chk("latency_valid", 32'(out_valid_w), 32'd1);
         chk("done_ready",    32'(in_ready_w),  32'd0);
      end
   endtask

   task automatic send_n(input logic [3:0] d, input int n);
      int w;
      for (int i = 0; i < n; i++) send(d, (i == n - 1), w);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int t;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_ready", 32'(in_ready_w),  32'd1);
      chk("rst_valid", 32'(out_valid_w), 32'd0);
      chk("rst_sum",   32'(sum_w),       32'd0);
      chk("rst_count", 32'(cnt_w),       32'd0);
      chk("rst_ovf",   32'(ovf_w),       32'd0);

      // 1 + 1.5 - 6 = -3.5 -> -7 half-units
      sb.push_back(mk(16'hFFF9, 8'd3, 1'b0, 6'h39, 2'd3, 1'b0));
      send(4'h2, 1'b0, w); send(4'h3, 1'b0, w); send(4'hF, 1'b1, w);

      // Negative zero, then a 5-cycle stall with input pending
      sb.push_back(mk(16'h0000, 8'd1, 1'b0, 6'h00, 2'd1, 1'b0));
      send(4'h8, 1'b1, w);
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 4'h5; in_last = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("stall_ready", 32'(in_ready_w),  32'd0);
         chk("stall_valid", 32'(out_valid_w), 32'd1);
         chk("stall_sum",   32'(sum_w),       32'd0);
         chk("stall_count", 32'(cnt_w),       32'd1);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      sb.push_back(mk(16'h0007, 8'd2, 1'b0, 6'h07, 2'd2, 1'b0));
      send(4'h5, 1'b0, w);
      chk("release_wait", 32'(w), 32'd1);
      send(4'h1, 1'b1, w);

      // Three +6.0: narrow instance overflows positively
      sb.push_back(mk(16'h0024, 8'd3, 1'b0, N_POS_OVF, 2'd3, 1'b1));
      send_n(4'h7, 3);
      // Three -6.0: narrow instance overflows negatively
      sb.push_back(mk(16'hFFDC, 8'd3, 1'b0, N_NEG_OVF, 2'd3, 1'b1));
      send_n(4'hF, 3);
      // Five +0.5: narrow counter saturates at 3
      sb.push_back(mk(16'h0005, 8'd5, 1'b0, 6'h05, 2'd3, 1'b0));
      send_n(4'h1, 5);

      // Reset in the middle of a vector
      send(4'h7, 1'b0, w); send(4'h7, 1'b0, w);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_valid", 32'(out_valid_w), 32'd0);
      chk("midrst_ready", 32'(in_ready_w),  32'd1);
      chk("midrst_sum",   32'(sum_w),       32'd0);
      chk("midrst_count", 32'(cnt_n),       32'd0);
      sb.push_back(mk(16'hFFFE, 8'd1, 1'b0, 6'h3E, 2'd1, 1'b0));
      send(4'hA, 1'b1, w);

      // Invalid cycle carrying data and last must be ignored
      sb.push_back(mk(16'h0005, 8'd2, 1'b0, 6'h05, 2'd2, 1'b0));
      send(4'h3, 1'b0, w);
      in_valid = 1'b0; in_data = 4'h7; in_last = 1'b1;
      @(posedge clk); #1;
      send(4'h2, 1'b1, w);

      t = 0;
      while (sb.size() != 0 && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (sb.size() != 0) begin
         n_checks++;
         $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
      end
      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fp4_dot_accumulator.md
Name: fp4_dot_accumulator

Overview:
- Sits directly downstream of the E2M1 FP4 multiplier.
- Consumes a stream of FP4 products (sign + 3-bit magnitude) through a valid/ready handshake.
- Converts each product to signed fixed-point in half-units (LSB = 0.5) and accumulates it. A vector is delimited by in_last.
- Emits the exact signed dot-product sum, the element count and an overflow flag through a second valid/ready handshake.

Parameters:
- ACC_W, 16, accumulator and out_sum width in bits, two's complement, LSB = 0.5; legal range 5..32.
- CNT_W, 8, element-counter width; legal range 1..16.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- in_valid_i  in  1  product valid.
- in_ready_o  out  1  block can accept a product.
- in_data_i  in  4  E2M1 product: [3] sign, [2:0] magnitude code.
- in_last_i  in  1  final product of the current vector.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts the result.
- out_sum_o  out  ACC_W  signed sum in half-units.
- out_count_o  out  CNT_W  number of products accepted in this vector; saturates at all-ones.
- out_ovf_o  out  1  sticky: accumulator overflowed during this vector.

Behaviour:
- Reset (rst_i=1 at a clock edge), output values:
  - out_valid_o=0, out_sum_o=0, out_count_o=0, out_ovf_o=0.
  - state=ACCUM, so in_ready_o=1 in the first cycle after reset.
  - Reset overrides any handshake in the same cycle.
- Magnitude decode to half-units:
  - 000→0, 001→1, 010→2, 011→3, 100→4, 101→6, 110→8, 111→12.
  - Sign bit set → negate.
  - Negative zero (1000) contributes 0 but still counts as an element.
- FSM states: ACCUM, DONE.
  - ACCUM:
    - in_ready_o=1, out_valid_o=0.
    - Accept when in_valid_i & in_ready_o: acc ← acc + term; count ← count+1 (hold at all-ones); ovf ← ovf | overflow.
    - If in_last_i is set on the accepted product, go to DONE next cycle.
  - DONE:
    - in_ready_o=0, out_valid_o=1.
    - out_sum_o, out_count_o and out_ovf_o hold stable while out_ready_i=0.
    - On out_valid_o & out_ready_i: clear acc/count/ovf and return to ACCUM. The next product can be accepted the following cycle.
- Latency: the last product accepted at edge t gives out_valid_o=1 in the cycle after edge t. The sum includes that product.
- Throughput:
  - One product per cycle within a vector.
  - One idle input cycle per vector (the DONE cycle), plus any backpressure cycles.
- in_ready_o is a registered function of state only. It must not combinationally depend on in_valid_i or out_ready_i.
- out_sum_o, out_count_o and out_ovf_o are driven from registers. Their values outside DONE are don't-care for checking; the implementation drives the live accumulator.
- Overflow detection:
  - Term sign-extended to ACC_W.
  - Overflow when acc and term have the same sign and the raw sum sign differs.
- in_data_i and in_last_i are ignored when in_valid_i=0.
- No output-to-input combinational path.

Optional Feature:
- Macro: FP4_ACC_SATURATE_EN.
- Defined:
  - On overflow, acc clamps to +(2^(ACC_W-1)-1) or -(2^(ACC_W-1)), and stays clamped until a term pulls it back in range.
  - out_ovf_o is still set (sticky).
- Undefined: acc wraps modulo 2^ACC_W; out_ovf_o set (sticky).

Decomposition:
- Package fp4_e2m1_pkg:
  - typedef fp4_e2m1_t, a packed struct {sign, mag[2:0]}.
  - Magnitude-code localparams.
  - Half-unit LUT constant.
  - State enum {ACCUM, DONE}.
- Sub-module fp4_e2m1_to_fixed:
  - Combinational decode of fp4_e2m1_t to a signed 5-bit half-unit term.
  - Reusable by a future CSA accumulation tree.

Test Plan:
- Vector in_data 0x2, 0x3, 0xF (last), no stalls → out_sum=-7 (0xFFF9 at ACC_W=16), count=3, ovf=0; out_valid_o one cycle after the last accept.
- Single element 0x8 with last → out_sum=0, count=1, ovf=0.
- Result pending with out_ready_i=0 for 5 cycles, in_valid_i=1 → in_ready_o=0, outputs stable all 5 cycles. Release → next vector accepted the following cycle; its sum starts from 0.
- ACC_W=6, three 0x7 products with last:
  - Macro undefined → out_sum=-28, ovf=1.
  - FP4_ACC_SATURATE_EN defined → out_sum=31, ovf=1.
- CNT_W=2, five 0x1 products with last → count=3 (saturated), out_sum=5.
- rst_i asserted after two accepted products mid-vector → next cycle out_valid_o=0, in_ready_o=1. A following single-element vector 0xA with last gives out_sum=-2, count=1, ovf=0.
